mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port synchronous block RAM between the CPU's instruction-fetch port and its data (load/store) port. At most one access is issued to the RAM per cycle, and read data is routed back to the port that requested it. The block sits between the fetch/memory pipeline stages and the memory macro. It is the only agent driving the RAM's control pins.

## Interface
Parameters:
- ADDR_WIDTH, 14, word-address width into the RAM
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- STARVE_LIMIT, 4, consecutive contended losses before fetch is forced through (used only with MEM_ARB_FAIR_EN)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  fetch read request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_WIDTH  fetch word address
- if_resp_valid  out  1  fetch read data valid (1-cycle pulse)
- if_resp_data  out  DATA_WIDTH  fetch read data
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_addr  in  ADDR_WIDTH  data word address
- d_req_we  in  DATA_WIDTH/8  byte write enables; all-zero means read
- d_req_wdata  in  DATA_WIDTH  store data
- d_resp_valid  out  1  load data valid (1-cycle pulse)
- d_resp_data  out  DATA_WIDTH  load data
- mem_en  out  1  RAM enable
- mem_we  out  DATA_WIDTH/8  RAM byte write enables
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_din  out  DATA_WIDTH  RAM write data
- mem_dout  in  DATA_WIDTH  RAM read data, valid one cycle after a read enable
- conflict_count  out  32  saturating count of cycles with both requests valid

## Operation
Handshake:
- A request transfers when valid && ready in the same cycle.
- Requesters hold addr, we and wdata stable while valid && !ready.
- Ready may depend combinationally on valid.
- Ready is asserted only for the granted port. At most one ready is high per cycle.
- With exactly one port valid, that port is granted.

Grant:
- Default policy is fixed priority: data wins on contention.

RAM drive:
- A granted request drives mem_en=1, mem_addr = requester address.
- For a data grant, mem_we = d_req_we and mem_din = d_req_wdata.
- A fetch grant drives mem_we = 0.
- With no grant: mem_en=0, mem_we=0.

Response tracking:
- A registered owner tag (NONE / IF / D) records each granted read.
- A store sets the tag to NONE. Stores produce no response.
- The cycle after a read grant, the owner's resp_valid pulses high for 1 cycle and its resp_data = mem_dout.
- The non-owner resp_valid stays 0. Both resp_data outputs are muxed from mem_dout.
- Reads and writes may be granted back-to-back. A full read every cycle is supported (throughput 1/cycle).

conflict_count:
- Increments on every cycle with if_req_valid && d_req_valid, outside reset.
- Saturates at 0xFFFF_FFFF.

Reset:
- Both ready outputs are low, mem_en=0, mem_we=0, both resp_valid=0, owner=NONE, starvation counter=0, conflict_count=0.
- Reset asserted mid-operation drops any pending response. resp_valid is 0 in the cycle following the reset edge.

## Timing
- Request to RAM: 0 cycles; combinational grant and mux.
- Read latency: grant cycle N → resp_valid in cycle N+1.
- No combinational path from mem_dout to any ready or mem_* output.
- Registered state is limited to: owner tag, starvation counter, conflict_count.
- A simultaneous store (data) and fetch: the store completes in cycle N, and fetch is granted in N+1 at the earliest.

## Configuration
MEM_ARB_FAIR_EN:
- Defined:
  - A starvation counter increments each cycle fetch is valid but loses to data.
  - It clears when fetch is granted or fetch is not valid.
  - When the counter equals STARVE_LIMIT and both ports are valid, fetch is granted and the counter clears.
- Undefined:
  - Pure data priority. The counter is absent. STARVE_LIMIT is ignored.

## Test plan
- Fetch only, addr 0x10 holding 0x0000_0013 → if_req_ready=1 same cycle; if_resp_valid=1 with 0x0000_0013 next cycle; d_resp_valid=0.
- Store 0xDEAD_BEEF to 0x20 with we=4'b1111, then load 0x20 → no response for the store; d_resp_data=0xDEAD_BEEF one cycle after the load grant.
- Store we=4'b0001 data 0x0000_00AA over 0x1122_3344, then read → 0x1122_33AA.
- Both valid for 10 cycles, macro undefined → data granted all 10 cycles; if_req_ready=0 throughout; conflict_count=10.
- Both valid continuously, MEM_ARB_FAIR_EN defined, STARVE_LIMIT=4 → grants D,D,D,D,IF repeating; if_resp_valid one cycle after each IF grant.
- Fetch granted, then rst asserted the next cycle → if_resp_valid=0 in the cycle after the reset edge; all outputs at reset values; conflict_count=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous block RAM between the
// instruction-fetch port (read-only) and the data port (load/store).
//
// Only one access reaches the RAM per cycle. Grant and the RAM mux are
// combinational. Read data comes back one cycle after the grant and is
// steered to whichever port issued the read.
//
// Optional feature macro: MEM_ARB_FAIR_EN
//   undefined -> pure data priority; STARVE_LIMIT is ignored
//   defined   -> after STARVE_LIMIT consecutive contended losses, fetch
//                is forced through for one cycle
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   if_req_*             fetch request (valid/ready/addr)
//   if_resp_*            fetch response (1-cycle valid pulse + data)
//   d_req_*              data request (valid/ready/addr/we/wdata)
//   d_resp_*             load response (1-cycle valid pulse + data)
//   mem_en/we/addr/din   RAM control and write data
//   mem_dout             RAM read data (one cycle after a read enable)
//   conflict_count       saturating count of cycles with both ports valid
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   if_req_addr,
  output logic                    if_resp_valid,
  output logic [DATA_WIDTH-1:0]   if_resp_data,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic [ADDR_WIDTH-1:0]   d_req_addr,
  input  logic [DATA_WIDTH/8-1:0] d_req_we,
  input  logic [DATA_WIDTH-1:0]   d_req_wdata,
  output logic                    d_resp_valid,
  output logic [DATA_WIDTH-1:0]   d_resp_data,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout,
  output logic [31:0]             conflict_count
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

  owner_e      owner_q, owner_d;
  logic [31:0] conflict_q, conflict_d;
  logic        if_gnt, d_gnt;
  logic        both_valid;

  assign both_valid = if_req_valid && d_req_valid;

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;
  logic          force_if;

  // Fetch has been starved long enough: let it through once.
  assign force_if = both_valid && (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if_gnt = if_req_valid && (!d_req_valid || force_if);
      d_gnt  = d_req_valid && !force_if;
    end
  end

  // Counts consecutive cycles where fetch waits behind data; cannot pass
  // STARVE_LIMIT since reaching it forces the next fetch grant.
  always_comb begin
    starve_d = starve_q;
    if (!if_req_valid || if_gnt) starve_d = '0;
    else if (d_gnt)              starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT == 0);

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      d_gnt  = d_req_valid;
      if_gnt = if_req_valid && !d_req_valid;
    end
  end
`endif

  assign if_req_ready = if_gnt;
  assign d_req_ready  = d_gnt;

  // RAM drive: data address/we/wdata when data owns the slot, fetch
  // address otherwise. mem_din is don't-care unless a write is enabled.
  assign mem_en   = if_gnt || d_gnt;
  assign mem_we   = d_gnt ? d_req_we : '0;
  assign mem_addr = d_gnt ? d_req_addr : if_req_addr;
  assign mem_din  = d_req_wdata;

  // Owner tag: who receives mem_dout next cycle. Stores produce nothing.
  always_comb begin
    owner_d = OWN_NONE;
    if (d_gnt && (d_req_we == '0)) owner_d = OWN_D;
    else if (if_gnt)               owner_d = OWN_IF;
  end

  always_comb begin
    conflict_d = conflict_q;
    if (both_valid && (conflict_q != 32'hFFFF_FFFF))
      conflict_d = conflict_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      conflict_q <= '0;
    end else begin
      owner_q    <= owner_d;
      conflict_q <= conflict_d;
    end
  end

  assign if_resp_valid  = (owner_q == OWN_IF);
  assign d_resp_valid   = (owner_q == OWN_D);
  assign if_resp_data   = mem_dout;
  assign d_resp_data    = mem_dout;
  assign conflict_count = conflict_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM on the mem_* pins,
// an independent reference memory updated from stimulus, and a queue of
// expected read responses.
module tb_mem_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int DEPTH = 1 << AW;
  localparam logic [1:0] G_NONE = 2'd0, G_IF = 2'd1, G_D = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready;
  logic [AW-1:0] if_req_addr;
  logic          if_resp_valid;
  logic [DW-1:0] if_resp_data;
  logic          d_req_valid, d_req_ready;
  logic [AW-1:0] d_req_addr;
  logic [BW-1:0] d_req_we;
  logic [DW-1:0] d_req_wdata;
  logic          d_resp_valid;
  logic [DW-1:0] d_resp_data;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic [31:0]   conflict_count;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .conflict_count(conflict_count)
  );

  // Behavioural single-port RAM, read-first, driven only by DUT pins.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < BW; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      mem_dout <= ram[mem_addr];
    end
  end

  // Reference memory, updated by the bench from its own stimulus.
  logic [DW-1:0] mdl [DEPTH];

  typedef struct {
    logic          is_if;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_conf = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Checks grant and RAM drive for one cycle, then the response visible
  // after the clock edge against the scoreboard.
  task automatic cyc(input logic ifv, input logic [AW-1:0] ifa,
                     input logic dv, input logic [AW-1:0] da,
                     input logic [BW-1:0] we, input logic [DW-1:0] wd,
                     input logic [1:0] exp_g);
    exp_t e;
    if_req_valid = ifv; if_req_addr = ifa;
    d_req_valid = dv; d_req_addr = da; d_req_we = we; d_req_wdata = wd;
    #1;
    chk("if_ready", {31'd0, if_req_ready}, {31'd0, exp_g == G_IF});
    chk("d_ready",  {31'd0, d_req_ready},  {31'd0, exp_g == G_D});
    chk("mem_en",   {31'd0, mem_en},       {31'd0, exp_g != G_NONE});
    chk("mem_we",   {28'd0, mem_we},       {28'd0, (exp_g == G_D) ? we : 4'd0});
    if (exp_g == G_IF) begin
      chk("mem_addr_if", {18'd0, mem_addr}, {18'd0, ifa});
      e.is_if = 1'b1; e.data = mdl[ifa]; exp_q.push_back(e);
    end else if (exp_g == G_D) begin
      chk("mem_addr_d", {18'd0, mem_addr}, {18'd0, da});
      if (we == '0) begin
        e.is_if = 1'b0; e.data = mdl[da]; exp_q.push_back(e);
      end else begin
        chk("mem_din", mem_din, wd);
        for (int b = 0; b < BW; b++)
          if (we[b]) mdl[da][8*b +: 8] = wd[8*b +: 8];
      end
    end
    if (ifv && dv) exp_conf++;
    @(posedge clk); #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.is_if) begin
        chk("if_resp_valid", {31'd0, if_resp_valid}, 32'd1);
        chk("if_resp_data",  if_resp_data, e.data);
        chk("d_resp_quiet",  {31'd0, d_resp_valid}, 32'd0);
      end else begin
        chk("d_resp_valid",  {31'd0, d_resp_valid}, 32'd1);
        chk("d_resp_data",   d_resp_data, e.data);
        chk("if_resp_quiet", {31'd0, if_resp_valid}, 32'd0);
      end
    end else begin
      chk("if_resp_none", {31'd0, if_resp_valid}, 32'd0);
      chk("d_resp_none",  {31'd0, d_resp_valid},  32'd0);
    end
    chk("conflict_count", conflict_count, exp_conf);
  endtask

  // Two reset cycles with both requests pending; checks reset outputs.
  task automatic do_reset();
    rst = 1'b1;
    if_req_valid = 1'b1; d_req_valid = 1'b1;
    d_req_we = '0; if_req_addr = '0; d_req_addr = '0; d_req_wdata = '0;
    #1;
    chk("rst_if_ready", {31'd0, if_req_ready}, 32'd0);
    chk("rst_d_ready",  {31'd0, d_req_ready},  32'd0);
    chk("rst_mem_en",   {31'd0, mem_en},       32'd0);
    chk("rst_mem_we",   {28'd0, mem_we},       32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_resp",  {31'd0, if_resp_valid}, 32'd0);
    chk("rst_d_resp",   {31'd0, d_resp_valid},  32'd0);
    chk("rst_conflict", conflict_count, 32'd0);
    exp_q.delete();
    exp_conf = 0;
    rst = 1'b0;
    if_req_valid = 1'b0; d_req_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] g;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = {i[15:0], ~i[15:0]};
      mdl[i] = {i[15:0], ~i[15:0]};
    end
    ram[14'h10] = 32'h0000_0013; mdl[14'h10] = 32'h0000_0013;
    ram[14'h30] = 32'h1122_3344; mdl[14'h30] = 32'h1122_3344;
    mem_dout = '0;
    rst = 1'b1;
    if_req_valid = 0; if_req_addr = 0;
    d_req_valid = 0; d_req_addr = 0; d_req_we = 0; d_req_wdata = 0;
    @(negedge clk);
    do_reset();

    // Fetch only.
    cyc(1, 14'h10, 0, 0, 4'h0, 0, G_IF);
    // Full store then load.
    cyc(0, 0, 1, 14'h20, 4'hF, 32'hDEAD_BEEF, G_D);
    cyc(0, 0, 1, 14'h20, 4'h0, 0, G_D);
    // Byte-lane store then load.
    cyc(0, 0, 1, 14'h30, 4'h1, 32'h0000_00AA, G_D);
    cyc(0, 0, 1, 14'h30, 4'h0, 0, G_D);
    chk("byte_merge_model", mdl[14'h30], 32'h1122_33AA);
    // Back-to-back mixed reads and an idle cycle.
    cyc(1, 14'h41, 0, 0, 4'h0, 0, G_IF);
    cyc(0, 0, 1, 14'h52, 4'h0, 0, G_D);
    cyc(1, 14'h10, 0, 0, 4'h0, 0, G_IF);
    cyc(0, 0, 0, 0, 4'h0, 0, G_NONE);
    // Store contended with fetch: store first, fetch next cycle.
    cyc(1, 14'h20, 1, 14'h20, 4'hC, 32'h5A5A_0000, G_D);
    cyc(1, 14'h20, 0, 0, 4'h0, 0, G_IF);

    // Continuous contention for 10 cycles from a clean reset.
    do_reset();
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_FAIR_EN
      g = ((k % 5) == 4) ? G_IF : G_D;
`else
      g = G_D;
`endif
      cyc(1, 14'(16'h100 + k), 1, 14'(16'h200 + k), 4'h0, 0, g);
    end
    chk("conflict_10", conflict_count, 32'd10);

    // Reset right after a fetch grant drops everything.
    cyc(1, 14'h10, 0, 0, 4'h0, 0, G_IF);
    rst = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 14'h10;
    #1;
    chk("midrst_if_ready", {31'd0, if_req_ready}, 32'd0);
    chk("midrst_mem_en",   {31'd0, mem_en}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_if_resp",  {31'd0, if_resp_valid}, 32'd0);
    chk("midrst_d_resp",   {31'd0, d_resp_valid}, 32'd0);
    chk("midrst_conflict", conflict_count, 32'd0);
    chk("midrst_mem_we",   {28'd0, mem_we}, 32'd0);
    rst = 1'b0; if_req_valid = 1'b0;
    exp_q.delete(); exp_conf = 0;
    cyc(1, 14'h30, 0, 0, 4'h0, 0, G_IF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
